aes_sbox_pipe: RTL and testbench

//  Multi-lane, pipelined AES byte-substitution engine. Replaces the purely combinational inverse-table lookup.

---
 rtl/aes_sbox_pipe.sv | 195 +++++++++++++++++++
 tb/tb_aes_sbox_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_pipe.sv
// Multi-lane pipelined AES byte substitution (forward or inverse S-box chosen per beat)
// with a valid/ready stream interface and full backpressure; latency is STAGES cycles.
module aes_sbox_pipe #(
    parameter int LANES  = 2,
    parameter int STAGES = 2,
    parameter int USER_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [USER_W-1:0]    in_user,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [USER_W-1:0]    out_user,
    output logic                 busy
);
    localparam int DW = 8 * LANES;

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
        endcase
        return s;
    endfunction

    logic [DW-1:0] w_lut_in;
    logic [DW-1:0] w_lut_out;
    logic          w_lut_inv;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_lut_out[8*gi +: 8] = w_lut_inv ? inv_sbox(w_lut_in[8*gi +: 8])
                                                : fwd_sbox(w_lut_in[8*gi +: 8]);
    end

    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("aes_sbox_pipe: LANES must be in 1..16");
    end

    if (STAGES == 1) begin : g_one
        // Lookup happens on the input side; only the result is registered.
        logic              r_valid;
        logic [DW-1:0]     r_data;
        logic [USER_W-1:0] r_user;

        assign w_lut_in  = in_data;
        assign w_lut_inv = in_inv;
        assign in_ready  = ~r_valid | out_ready;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_user  <= '0;
            end else if (in_ready) begin
                r_valid <= in_valid;
                if (in_valid) begin
                    r_data <= w_lut_out;
                    r_user <= in_user;
                end
            end
        end

        assign out_valid = r_valid;
        assign out_data  = r_data;
        assign out_user  = r_user;
        assign busy      = r_valid;
    end else if (STAGES == 2) begin : g_two
        logic              r_s1_valid;
        logic [DW-1:0]     r_s1_data;
        logic              r_s1_inv;
        logic [USER_W-1:0] r_s1_user;
        logic              r_s2_valid;
        logic [DW-1:0]     r_s2_data;
        logic [USER_W-1:0] r_s2_user;
        logic              w_s2_adv;

        // An empty S2 advances regardless of out_ready, so bubbles collapse.
        assign w_s2_adv  = ~r_s2_valid | out_ready;
        assign in_ready  = ~r_s1_valid | w_s2_adv;
        assign w_lut_in  = r_s1_data;
        assign w_lut_inv = r_s1_inv;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s1_valid <= 1'b0;
                r_s1_data  <= '0;
                r_s1_inv   <= 1'b0;
                r_s1_user  <= '0;
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
                r_s2_user  <= '0;
            end else begin
                if (in_ready) begin
                    r_s1_valid <= in_valid;
                    if (in_valid) begin
                        r_s1_data <= in_data;
                        r_s1_inv  <= in_inv;
                        r_s1_user <= in_user;
                    end
                end
                if (w_s2_adv) begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= w_lut_out;
                        r_s2_user <= r_s1_user;
                    end
                end
            end
        end

        assign out_valid = r_s2_valid;
        assign out_data  = r_s2_data;
        assign out_user  = r_s2_user;
        assign busy      = r_s1_valid | r_s2_valid;
    end else begin : g_bad_stages
        $error("aes_sbox_pipe: STAGES must be 1 or 2");
    end
endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Bench for aes_sbox_pipe: S-box reference built from GF(2^8) inversion plus the affine map,
// scoreboard of accepted beats, directed cases then randomised traffic with backpressure.
module tb_aes_sbox_pipe;
    localparam int LANES  = 2;
    localparam int STAGES = 2;
    localparam int USER_W = 4;
    localparam int DW     = 8 * LANES;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_inv = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic [USER_W-1:0] in_user = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     out_data;
    logic [USER_W-1:0] out_user;
    logic              busy;

    aes_sbox_pipe #(.LANES(LANES), .STAGES(STAGES), .USER_W(USER_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_data(in_data), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_user(out_user), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]     data;
        logic [USER_W-1:0] user;
        int                cyc;
    } beat_t;

    beat_t             sb[$];
    logic [7:0]        ref_fwd[256];
    logic [7:0]        ref_inv[256];
    int                n_vec = 0;
    int                n_err = 0;
    int                cyc = 0;
    bit                lat_en = 1'b1;
    bit                rnd_ready = 1'b0;
    bit                prev_stall = 1'b0;
    logic [DW-1:0]     prev_data = '0;
    logic [USER_W-1:0] prev_user = '0;
    logic [DW-1:0]     drv_exp = '0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic void build_model();
        logic [7:0] b;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            ref_fwd[x] = s;
            ref_inv[s] = 8'(x);
        end
    endfunction

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r = '0;
        for (int k = 0; k < LANES; k++)
            r[8*k +: 8] = inv ? ref_inv[d[8*k +: 8]] : ref_fwd[d[8*k +: 8]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes and outputs at the falling edge, return just after the rising edge.
    task automatic cycle(output bit acc);
        beat_t b;
        beat_t e;
        @(negedge clk);
        cyc++;
        if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
            check("stall_user", 32'(out_user), 32'(prev_user));
        end
        acc = in_valid && in_ready;
        if (acc) begin
            b.data = drv_exp;
            b.user = in_user;
            b.cyc  = cyc;
            sb.push_back(b);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_beat", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("data", 32'(out_data), 32'(e.data));
                check("user", 32'(out_user), 32'(e.user));
                if (lat_en) check("latency", 32'(cyc - e.cyc), 32'(STAGES));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_user  = out_user;
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(3) != 0);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic inv,
                        input logic [USER_W-1:0] u, input logic [DW-1:0] exp);
        bit acc = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        in_user  = u;
        drv_exp  = exp;
        while (!acc && n < 64) begin
            cycle(acc);
            n++;
        end
        n_vec++;
        assert (acc) else begin
            n_err++;
            $error("FAIL accept_timeout: observed no accept after %0d cycles, expected accept", n);
        end
    endtask

    task automatic idle_cycle();
        bit acc;
        in_valid = 1'b0;
        in_data  = 'x;
        in_inv   = 1'bx;
        cycle(acc);
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_data   = 'x;
        in_inv    = 1'bx;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            cycle(acc);
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int acc_cnt;
        int c0;
        logic [7:0] xb;
        logic [7:0] nb;
        logic [DW-1:0] d;
        logic inv;

        build_model();

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_user", 32'(out_user), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // First beat and its latency, then a mode-switch pair
        send(16'h0000, 1'b0, 4'h1, 16'h6363);
        drain();
        send(16'h6316, 1'b1, 4'h2, 16'h00FF);
        send(16'h00FF, 1'b0, 4'h3, 16'h6316);
        drain();

        // Back-to-back alternating modes: one accept per cycle
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send(16'h0153, 1'b0, USER_W'(i), 16'h7CED);
            else            send(16'h7CED, 1'b1, USER_W'(i), 16'h0153);
        end
        check("b2b_cycles", 32'(cyc - c0), 32'd8);
        drain();

        // Backpressure: exactly two beats fit while the output is stalled
        lat_en    = 1'b0;
        out_ready = 1'b0;
        acc_cnt   = 0;
        acc       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (acc) begin
                d        = DW'($urandom);
                inv      = 1'($urandom);
                in_valid = 1'b1;
                in_data  = d;
                in_inv   = inv;
                in_user  = USER_W'(i + 4);
                drv_exp  = model(d, inv);
            end
            cycle(acc);
            if (acc) acc_cnt++;
        end
        check("bp_accepts", 32'(acc_cnt), 32'(STAGES));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        drain();

        // Every byte value in both lanes and both modes, plus the round trip, under random out_ready
        rnd_ready = 1'b1;
        for (int x = 0; x < 256; x++) begin
            xb = 8'(x);
            nb = ~xb;
            send({nb, xb}, 1'b0, USER_W'(x), model({nb, xb}, 1'b0));
            send({nb, xb}, 1'b1, USER_W'(x + 1), model({nb, xb}, 1'b1));
            send({ref_fwd[nb], ref_fwd[xb]}, 1'b1, USER_W'(x + 2), {nb, xb});
        end
        drain();

        // Random traffic with gaps and backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(4) == 0) begin
                idle_cycle();
            end else begin
                d   = DW'($urandom);
                inv = 1'($urandom);
                send(d, inv, USER_W'($urandom), model(d, inv));
            end
        end
        drain();

        // Asynchronous reset with the pipe full
        out_ready = 1'b0;
        send(16'h1234, 1'b0, 4'hA, model(16'h1234, 1'b0));
        send(16'hABCD, 1'b1, 4'hB, model(16'hABCD, 1'b1));
        in_valid = 1'b0;
        check("full_busy", 32'(busy), 32'd1);
        check("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_user", 32'(out_user), 32'd0);
        sb.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        lat_en    = 1'b1;
        out_ready = 1'b1;
        send(16'h5A0F, 1'b0, 4'hC, model(16'h5A0F, 1'b0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
